// File: rtl/shared_mem_ble_pkg.sv
// rtl/shared_mem_ble_pkg.sv - bank-state encoding, mode constants and word-count helper
package shared_mem_ble_pkg;

  typedef enum logic [1:0] {
    FREE     = 2'd0,
    FILLING  = 2'd1,
    READY    = 2'd2,
    DRAINING = 2'd3
  } bank_state_e;

  localparam logic MODE_TX = 1'b1;
  localparam logic MODE_RX = 1'b0;

  // Word counts are computed wide enough that a 17-bit byte length never wraps.
  localparam int WLEN_W = 18;

  // Number of words needed to carry size bytes, rounded up.
  function automatic logic [WLEN_W-1:0] calc_wlen(input logic [16:0] size, input int bpw);
    logic [WLEN_W-1:0] num;
    num = {1'b0, size} + WLEN_W'(bpw - 1);
    return num / WLEN_W'(bpw);
  endfunction

endpackage

// File: rtl/sdp_ram_ble.sv
// rtl/sdp_ram_ble.sv - simple dual-port RAM, one write port and one registered read port
module sdp_ram_ble #(
  parameter int DATA = 32,
  parameter int AW   = 9
) (
  input  logic            clk,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [DATA-1:0] wr_data,
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_addr,
  output logic [DATA-1:0] rd_data
);

  logic [DATA-1:0] mem_q [2**AW];
  logic [DATA-1:0] rd_data_q;

  // Storage array and read register; contents are not reset, only bank state is.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/shared_mem_pingpong_ble.sv
// rtl/shared_mem_pingpong_ble.sv - ping-pong packet buffer between AHB slicer and BLE PHY
module shared_mem_pingpong_ble
  import shared_mem_ble_pkg::*;
#(
  parameter int DATA  = 32,
  parameter int AD    = 8,
  parameter int BANKS = 2
) (
  input  logic            hclk,
  input  logic            reset,
  input  logic            mode,
  input  logic [16:0]     data_size,
  input  logic            err_clr,
  input  logic [AD-1:0]   fifo_address,
  input  logic            fifo_write_en,
  input  logic            fifo_read_en,
  input  logic [DATA-1:0] fifo_input_from_slicer,
  output logic [DATA-1:0] fifo_out_to_slicer,
  input  logic            fifo_commit,
  input  logic            fifo_release,
  input  logic            re,
  output logic [DATA-1:0] data_out,
  output logic            data_out_valid,
  input  logic            we,
  input  logic [DATA-1:0] data_in,
  output logic            fifo_full,
  output logic            fifo_empty,
  output logic [AD-1:0]   fifo_rd_pntr,
  output logic            w_done_flag,
  output logic            tx_irq,
  output logic            err_ovf,
  output logic            err_udf
);

  localparam int BI  = $clog2(BANKS);
  localparam int WL  = AD + 1;
  localparam int BPW = DATA / 8;
  localparam logic [WL-1:0] DEPTH = WL'(1) << AD;

  bank_state_e     bank_st_q [BANKS];
  bank_state_e     bank_st_d [BANKS];
  logic [WL-1:0]   wlen_q [BANKS];
  logic [WL-1:0]   wlen_d [BANKS];
  logic [BI-1:0]   prod_q, prod_d, cons_q, cons_d;
  logic [AD-1:0]   rd_pntr_q, rd_pntr_d, wr_pntr_q, wr_pntr_d;
  logic            mode_q, mode_d;
  logic            err_ovf_q, err_ovf_d, err_udf_q, err_udf_d;
  logic            w_done_q, w_done_d, tx_irq_q, tx_irq_d;
  logic            tx_rd_q, tx_rd_d, rx_rd_q, rx_rd_d;
  logic [DATA-1:0] dout_hold_q, dout_hold_d, fout_hold_q, fout_hold_d;

  logic [WLEN_W-1:0] wlen_raw;
  logic              wlen_zero, wlen_clamp;
  logic [WL-1:0]     wlen_eff;
  logic              any_free, any_ready, all_free;
  logic              prod_open, cons_ready, rx_last, ovf_set, udf_set;
  logic              ram_we, ram_re;
  logic [BI+AD-1:0]  ram_waddr, ram_raddr;
  logic [DATA-1:0]   ram_wdata, ram_rdata;

  // Packet length in words, clamped to one bank.
  always_comb begin
    wlen_raw   = calc_wlen(data_size, BPW);
    wlen_zero  = (wlen_raw == '0);
    wlen_clamp = (wlen_raw > WLEN_W'(DEPTH));
    wlen_eff   = wlen_clamp ? DEPTH : wlen_raw[WL-1:0];
  end

  // Summary of bank occupancy for the full/empty flags and the mode lock.
  always_comb begin
    any_free  = 1'b0;
    any_ready = 1'b0;
    all_free  = 1'b1;
    for (int i = 0; i < BANKS; i++) begin
      if (bank_st_q[i] == FREE) any_free = 1'b1;
      else                      all_free = 1'b0;
      if (bank_st_q[i] == READY || bank_st_q[i] == DRAINING) any_ready = 1'b1;
    end
  end

  // Producer and consumer handling; they always act on different banks.
  always_comb begin
    bank_st_d  = bank_st_q;
    wlen_d     = wlen_q;
    prod_d     = prod_q;
    cons_d     = cons_q;
    rd_pntr_d  = rd_pntr_q;
    wr_pntr_d  = wr_pntr_q;
    ovf_set    = 1'b0;
    udf_set    = 1'b0;
    w_done_d   = 1'b0;
    tx_irq_d   = 1'b0;
    tx_rd_d    = 1'b0;
    rx_rd_d    = 1'b0;
    rx_last    = 1'b0;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    ram_waddr  = {prod_q, fifo_address};
    ram_wdata  = fifo_input_from_slicer;
    ram_raddr  = {cons_q, rd_pntr_q};
    prod_open  = (bank_st_q[prod_q] == FREE) || (bank_st_q[prod_q] == FILLING);
    cons_ready = (bank_st_q[cons_q] == READY) || (bank_st_q[cons_q] == DRAINING);
    mode_d     = all_free ? mode : mode_q;

    if (mode_q == MODE_TX) begin
      if (fifo_write_en) begin
        if (prod_open) begin
          ram_we = 1'b1;
          bank_st_d[prod_q] = FILLING;
        end else ovf_set = 1'b1;
      end
      if (fifo_commit) begin
        if (!prod_open) ovf_set = 1'b1;
        else if (wlen_zero) udf_set = 1'b1;
        else begin
          wlen_d[prod_q]    = wlen_eff;
          bank_st_d[prod_q] = READY;
          prod_d            = prod_q + BI'(1);
          if (wlen_clamp) udf_set = 1'b1;
        end
      end
      if (re) begin
        if (cons_ready) begin
          ram_re  = 1'b1;
          tx_rd_d = 1'b1;
          if ({1'b0, rd_pntr_q} == wlen_q[cons_q] - WL'(1)) begin
            bank_st_d[cons_q] = FREE;
            tx_irq_d          = 1'b1;
            rd_pntr_d         = '0;
            cons_d            = cons_q + BI'(1);
          end else begin
            bank_st_d[cons_q] = DRAINING;
            rd_pntr_d         = rd_pntr_q + AD'(1);
          end
        end else udf_set = 1'b1;
      end
    end else begin
      ram_waddr = {prod_q, wr_pntr_q};
      ram_wdata = data_in;
      ram_raddr = {cons_q, fifo_address};
      if (we) begin
        if (bank_st_q[prod_q] == FREE) begin
          if (wlen_zero) udf_set = 1'b1;
          else begin
            ram_we            = 1'b1;
            wlen_d[prod_q]    = wlen_eff;
            bank_st_d[prod_q] = FILLING;
            wr_pntr_d         = AD'(1);
            rx_last           = (wlen_eff == WL'(1));
            if (wlen_clamp) udf_set = 1'b1;
          end
        end else if (bank_st_q[prod_q] == FILLING) begin
          ram_we    = 1'b1;
          wr_pntr_d = wr_pntr_q + AD'(1);
          rx_last   = ({1'b0, wr_pntr_q} == wlen_q[prod_q] - WL'(1));
        end else ovf_set = 1'b1;
        if (rx_last) begin
          bank_st_d[prod_q] = READY;
          w_done_d          = 1'b1;
          wr_pntr_d         = '0;
          prod_d            = prod_q + BI'(1);
        end
      end
      if (fifo_read_en) begin
        if (cons_ready) begin
          ram_re            = 1'b1;
          rx_rd_d           = 1'b1;
          bank_st_d[cons_q] = DRAINING;
        end else udf_set = 1'b1;
      end
      if (fifo_release) begin
        if (cons_ready) begin
          bank_st_d[cons_q] = FREE;
          cons_d            = cons_q + BI'(1);
        end else udf_set = 1'b1;
      end
    end

    err_ovf_d   = err_clr ? 1'b0 : (err_ovf_q | ovf_set);
    err_udf_d   = err_clr ? 1'b0 : (err_udf_q | udf_set);
    dout_hold_d = data_out;
    fout_hold_d = fifo_out_to_slicer;
  end

  // All control state; reset drops every bank back to FREE at once.
  always_ff @(posedge hclk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BANKS; i++) begin
        bank_st_q[i] <= FREE;
        wlen_q[i]    <= '0;
      end
      prod_q      <= '0;
      cons_q      <= '0;
      rd_pntr_q   <= '0;
      wr_pntr_q   <= '0;
      mode_q      <= MODE_TX;
      err_ovf_q   <= 1'b0;
      err_udf_q   <= 1'b0;
      w_done_q    <= 1'b0;
      tx_irq_q    <= 1'b0;
      tx_rd_q     <= 1'b0;
      rx_rd_q     <= 1'b0;
      dout_hold_q <= '0;
      fout_hold_q <= '0;
    end else begin
      bank_st_q   <= bank_st_d;
      wlen_q      <= wlen_d;
      prod_q      <= prod_d;
      cons_q      <= cons_d;
      rd_pntr_q   <= rd_pntr_d;
      wr_pntr_q   <= wr_pntr_d;
      mode_q      <= mode_d;
      err_ovf_q   <= err_ovf_d;
      err_udf_q   <= err_udf_d;
      w_done_q    <= w_done_d;
      tx_irq_q    <= tx_irq_d;
      tx_rd_q     <= tx_rd_d;
      rx_rd_q     <= rx_rd_d;
      dout_hold_q <= dout_hold_d;
      fout_hold_q <= fout_hold_d;
    end
  end

  sdp_ram_ble #(.DATA(DATA), .AW(BI + AD)) u_ram (
    .clk     (hclk),
    .wr_en   (ram_we),
    .wr_addr (ram_waddr),
    .wr_data (ram_wdata),
    .rd_en   (ram_re),
    .rd_addr (ram_raddr),
    .rd_data (ram_rdata)
  );

  // Each read bus shows fresh RAM data only on its own read cycle and holds otherwise.
  assign data_out           = tx_rd_q ? ram_rdata : dout_hold_q;
  assign fifo_out_to_slicer = rx_rd_q ? ram_rdata : fout_hold_q;
  assign data_out_valid     = tx_rd_q;
  assign fifo_full          = !any_free;
  assign fifo_empty         = !any_ready;
  assign fifo_rd_pntr       = rd_pntr_q;
  assign w_done_flag        = w_done_q;
  assign tx_irq             = tx_irq_q;
  assign err_ovf            = err_ovf_q;
  assign err_udf            = err_udf_q;

endmodule

// File: tb/tb_shared_mem_pingpong_ble.sv
// tb/tb_shared_mem_pingpong_ble.sv - self-checking bench for shared_mem_pingpong_ble
module tb_shared_mem_pingpong_ble;

  logic        hclk, reset, mode, err_clr;
  logic [16:0] data_size;
  logic [7:0]  fifo_address, fifo_rd_pntr;
  logic        fifo_write_en, fifo_read_en, fifo_commit, fifo_release, re, we;
  logic [31:0] fifo_input_from_slicer, fifo_out_to_slicer, data_out, data_in;
  logic        data_out_valid, fifo_full, fifo_empty, w_done_flag, tx_irq, err_ovf, err_udf;

  int n_cmp = 0;
  int n_fail = 0;

  shared_mem_pingpong_ble #(.DATA(32), .AD(8), .BANKS(2)) dut (
    .hclk(hclk), .reset(reset), .mode(mode), .data_size(data_size), .err_clr(err_clr),
    .fifo_address(fifo_address), .fifo_write_en(fifo_write_en), .fifo_read_en(fifo_read_en),
    .fifo_input_from_slicer(fifo_input_from_slicer), .fifo_out_to_slicer(fifo_out_to_slicer),
    .fifo_commit(fifo_commit), .fifo_release(fifo_release), .re(re), .data_out(data_out),
    .data_out_valid(data_out_valid), .we(we), .data_in(data_in), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .fifo_rd_pntr(fifo_rd_pntr), .w_done_flag(w_done_flag),
    .tx_irq(tx_irq), .err_ovf(err_ovf), .err_udf(err_udf)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  typedef struct {
    int size;
    int words;
    bit udf;
  } vec_t;

  vec_t tbl[8];

  logic [31:0] word_q[$];
  int          len_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic ahb_write(input logic [7:0] addr, input logic [31:0] d);
    fifo_address = addr;
    fifo_input_from_slicer = d;
    fifo_write_en = 1'b1;
    tick();
    fifo_write_en = 1'b0;
  endtask

  task automatic commit(input int size);
    data_size = 17'(size);
    fifo_commit = 1'b1;
    tick();
    fifo_commit = 1'b0;
  endtask

  task automatic read_one();
    re = 1'b1;
    tick();
    re = 1'b0;
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  initial begin
    logic [31:0] w[6];
    logic [31:0] d0, d1;
    int cnt, n, sz;
    bit seen;

    tbl[0] = '{1, 1, 1'b0};
    tbl[1] = '{4, 1, 1'b0};
    tbl[2] = '{5, 2, 1'b0};
    tbl[3] = '{10, 3, 1'b0};
    tbl[4] = '{0, 0, 1'b1};
    tbl[5] = '{1024, 256, 1'b0};
    tbl[6] = '{1025, 256, 1'b1};
    tbl[7] = '{2000, 256, 1'b1};

    reset = 1'b1; mode = 1'b1; err_clr = 1'b0; data_size = '0;
    fifo_address = '0; fifo_write_en = 1'b0; fifo_read_en = 1'b0;
    fifo_input_from_slicer = '0; fifo_commit = 1'b0; fifo_release = 1'b0;
    re = 1'b0; we = 1'b0; data_in = '0;
    tick(); tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_data_out", data_out, 32'h0);
    check("rst_fifo_out", fifo_out_to_slicer, 32'h0);
    check("rst_flags", {data_out_valid, fifo_full, fifo_empty, w_done_flag, tx_irq, err_ovf, err_udf},
          32'b0010000);
    check("rst_rd_pntr", fifo_rd_pntr, 32'h0);

    // TX single packet: 10 bytes -> 3 words
    for (int i = 0; i < 3; i++) begin
      w[i] = $urandom;
      ahb_write(8'(i), w[i]);
    end
    commit(10);
    check("tx1_not_empty", fifo_empty, 1'b0);
    for (int i = 0; i < 3; i++) begin
      read_one();
      check("tx1_valid", data_out_valid, 1'b1);
      check("tx1_data", data_out, w[i]);
      check("tx1_irq", tx_irq, (i == 2));
    end
    check("tx1_empty_after", fifo_empty, 1'b1);
    check("tx1_rd_pntr_after", fifo_rd_pntr, 32'h0);

    // re while empty: no data, hold previous word, underflow
    read_one();
    check("udf_valid", data_out_valid, 1'b0);
    check("udf_hold", data_out, w[2]);
    check("udf_flag", err_udf, 1'b1);
    re = 1'b1; err_clr = 1'b1;
    tick();
    re = 1'b0; err_clr = 1'b0;
    check("errclr_priority", err_udf, 1'b0);

    // Ping-pong TX with overflow
    w[0] = $urandom; w[1] = $urandom; w[2] = $urandom; w[3] = $urandom;
    ahb_write(8'd0, w[0]); commit(4);
    ahb_write(8'd0, w[1]); commit(4);
    check("pp_full", fifo_full, 1'b1);
    ahb_write(8'd0, w[3]);
    check("pp_ovf", err_ovf, 1'b1);
    read_one();
    check("pp_drain0", data_out, w[0]);
    check("pp_irq0", tx_irq, 1'b1);
    check("pp_not_full", fifo_full, 1'b0);
    ahb_write(8'd0, w[2]); commit(4);
    read_one();
    check("pp_drain1", data_out, w[1]);
    read_one();
    check("pp_drain_bank0_again", data_out, w[2]);
    clear_err();
    check("pp_ovf_cleared", err_ovf, 1'b0);

    // Mode lock: a READY bank keeps the block in TX
    w[4] = $urandom;
    ahb_write(8'd0, w[4]); commit(4);
    mode = 1'b0;
    tick(); tick();
    read_one();
    check("lock_valid", data_out_valid, 1'b1);
    check("lock_data", data_out, w[4]);
    tick();
    read_one();
    check("rx_mode_re_ignored", data_out_valid, 1'b0);
    check("rx_mode_no_udf", err_udf, 1'b0);

    // RX framing: 8 bytes -> 2 words
    d0 = $urandom; d1 = $urandom;
    data_size = 17'd8;
    data_in = d0; we = 1'b1; tick();
    check("rx_wdone_first", w_done_flag, 1'b0);
    data_in = d1; tick(); we = 1'b0;
    check("rx_wdone", w_done_flag, 1'b1);
    check("rx_not_empty", fifo_empty, 1'b0);
    fifo_address = 8'd1; fifo_read_en = 1'b1; tick();
    check("rx_read1", fifo_out_to_slicer, d1);
    fifo_address = 8'd0; tick(); fifo_read_en = 1'b0;
    check("rx_read0", fifo_out_to_slicer, d0);
    fifo_release = 1'b1; tick(); fifo_release = 1'b0;
    check("rx_empty", fifo_empty, 1'b1);
    check("rx_no_udf", err_udf, 1'b0);
    fifo_release = 1'b1; tick(); fifo_release = 1'b0;
    check("rx_release_udf", err_udf, 1'b1);
    clear_err();

    // Length table in TX
    mode = 1'b1;
    tick();
    foreach (tbl[t]) begin
      clear_err();
      commit(tbl[t].size);
      if (tbl[t].words == 0) begin
        check($sformatf("tbl%0d_empty", t), fifo_empty, 1'b1);
        check($sformatf("tbl%0d_udf", t), err_udf, 1'b1);
      end else begin
        re = 1'b1; cnt = 0; seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
          tick();
          if (data_out_valid) cnt++;
          if (tx_irq) seen = 1'b1;
        end
        re = 1'b0;
        check($sformatf("tbl%0d_irq", t), seen, 1'b1);
        check($sformatf("tbl%0d_words", t), cnt, tbl[t].words);
        check($sformatf("tbl%0d_udf", t), err_udf, tbl[t].udf);
      end
    end
    clear_err();

    // Randomized TX traffic against a packet-queue model
    for (int it = 0; it < 40; it++) begin
      if (len_q.size() < 2 && (len_q.size() == 0 || $urandom_range(1, 0) == 1)) begin
        n = $urandom_range(6, 1);
        sz = (n - 1) * 4 + $urandom_range(4, 1);
        for (int i = 0; i < n; i++) w[i] = $urandom;
        for (int i = n - 1; i >= 0; i--) ahb_write(8'(i), w[i]);
        for (int i = 0; i < n; i++) word_q.push_back(w[i]);
        len_q.push_back(n);
        commit(sz);
        check("rnd_full", fifo_full, (len_q.size() == 2));
      end else begin
        n = len_q.pop_front();
        for (int i = 0; i < n; i++) begin
          read_one();
          check("rnd_data", data_out, word_q.pop_front());
          check("rnd_irq", tx_irq, (i == n - 1));
          if ($urandom_range(1, 0) == 1) tick();
        end
        check("rnd_empty", fifo_empty, (len_q.size() == 0));
      end
    end
    check("rnd_no_err", {err_ovf, err_udf}, 2'b00);

    // Reset in the middle of a drain
    while (len_q.size() > 0) begin
      n = len_q.pop_front();
      for (int i = 0; i < n; i++) begin
        read_one();
        void'(word_q.pop_front());
      end
    end
    for (int i = 0; i < 3; i++) ahb_write(8'(i), $urandom);
    commit(12);
    read_one();
    re = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("mid_rst_empty", fifo_empty, 1'b1);
    check("mid_rst_flags", {data_out_valid, fifo_full, w_done_flag, tx_irq, err_ovf, err_udf}, 32'h0);
    check("mid_rst_data", data_out, 32'h0);
    check("mid_rst_pntr", fifo_rd_pntr, 32'h0);
    re = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    check("post_rst_empty", fifo_empty, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
